// File: rtl/conbus_arb_dec_n_if.sv
// Flattened WISHBONE buses around the shared interconnect (index 0 = LSBs).
// "master" is the view of the attached agents, "slave" is the interconnect serving them.
interface conbus_arb_dec_n_if #(
  parameter int NM = 5,
  parameter int NS = 7
);
  logic [NM*32-1:0] m_dat_i;
  logic [NM*32-1:0] m_dat_o;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;

  logic [NS*32-1:0] s_dat_i;
  logic [NS*32-1:0] s_dat_o;
  logic [NS*32-1:0] s_adr_o;
  logic [NS*3-1:0]  s_cti_o;
  logic [NS*4-1:0]  s_sel_o;
  logic [NS-1:0]    s_we_o;
  logic [NS-1:0]    s_cyc_o;
  logic [NS-1:0]    s_stb_o;
  logic [NS-1:0]    s_ack_i;

  modport master (
    output m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport slave (
    input  m_dat_i, m_adr_i, m_cti_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_dat_o, s_adr_o, s_cti_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/conbus_arb_dec_n.sv
// Shared-bus WISHBONE interconnect: round-robin arbiter, mask/match address decoder,
// ack/err routing from the selected slave and a watchdog for unmapped or stalled accesses.

// Default address map: slave i claims decoded tag value i.
function automatic logic [63:0] conbus_arb_dec_n_match(input int ns, input int dec_w);
  logic [63:0] v;
  v = '0;
  for (int i = 0; i < ns; i++)
    v |= (64'(i) & ((64'd1 << dec_w) - 64'd1)) << (i * dec_w);
  return v;
endfunction

module conbus_arb_dec_n #(
  parameter int NM      = 5,
  parameter int NS      = 7,
  parameter int DEC_W   = 3,
  parameter logic [NS*DEC_W-1:0] S_MATCH = (NS*DEC_W)'(conbus_arb_dec_n_match(NS, DEC_W)),
  parameter logic [NS*DEC_W-1:0] S_MASK  = '1,
  parameter int TIMEOUT = 1023
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  conbus_arb_dec_n_if.slave bus
);
  localparam int GW   = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  logic [GW-1:0]    gnt;
  logic [GW-1:0]    gnt_nxt;
  logic [WD_W-1:0]  wd_cnt;
  logic             err_pend;
  logic             cyc_g;
  logic             stb_g;
  logic [31:0]      adr_g;
  logic [DEC_W-1:0] tag;
  logic [NS-1:0]    sel;
  logic [SW-1:0]    sel_idx;
  logic             hit;
  logic             ack_g;
  logic [31:0]      dat_sel;

  // Reset gates the granted request so slave strobes drop the moment reset asserts.
  assign cyc_g = bus.m_cyc_i[gnt] & sys_rst_n;
  assign stb_g = bus.m_stb_i[gnt] & sys_rst_n;
  assign adr_g = bus.m_adr_i[gnt*32 +: 32];
  assign tag   = adr_g[31 -: DEC_W];

  // Scanning downwards leaves the lowest matching slave as the winner.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    hit     = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (((tag ^ S_MATCH[i*DEC_W +: DEC_W]) & S_MASK[i*DEC_W +: DEC_W]) == '0) begin
        hit     = 1'b1;
        sel_idx = SW'(i);
      end
    end
    if (hit)
      sel[sel_idx] = 1'b1;
  end

  assign ack_g   = cyc_g & stb_g & hit & ~err_pend & bus.s_ack_i[sel_idx];
  assign dat_sel = hit ? bus.s_dat_i[sel_idx*32 +: 32] : 32'h0;

  // Closest requester after the current owner wins; the owner keeps the bus while cyc is high.
  always_comb begin
    gnt_nxt = gnt;
    if (!bus.m_cyc_i[gnt]) begin
      for (int k = NM - 1; k >= 1; k--) begin
        if (bus.m_cyc_i[(int'(gnt) + k) % NM])
          gnt_nxt = GW'((int'(gnt) + k) % NM);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gnt      <= '0;
      wd_cnt   <= '0;
      err_pend <= 1'b0;
    end else begin
      gnt <= gnt_nxt;
      if (err_pend) begin
        err_pend <= 1'b0;
        wd_cnt   <= '0;
      end else if (!(cyc_g && stb_g) || ack_g) begin
        wd_cnt <= '0;
      end else if (!hit || (TIMEOUT != 0 && wd_cnt == WD_LAST)) begin
        err_pend <= 1'b1;
      end else if (TIMEOUT != 0 && wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  always_comb begin
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (ack_g)
      bus.m_ack_o[gnt] = 1'b1;
    if (err_pend)
      bus.m_err_o[gnt] = 1'b1;
  end

  assign bus.m_dat_o = {NM{dat_sel}};
  assign bus.s_dat_o = {NS{bus.m_dat_i[gnt*32 +: 32]}};
  assign bus.s_adr_o = {NS{adr_g}};
  assign bus.s_cti_o = {NS{bus.m_cti_i[gnt*3 +: 3]}};
  assign bus.s_sel_o = {NS{bus.m_sel_i[gnt*4 +: 4]}};
  assign bus.s_we_o  = {NS{bus.m_we_i[gnt]}};
  assign bus.s_cyc_o = cyc_g ? sel : '0;
  assign bus.s_stb_o = (stb_g && !err_pend) ? sel : '0;
endmodule

// File: tb/tb_conbus_arb_dec_n.sv
// Self-checking bench for conbus_arb_dec_n: directed scenarios plus a randomized run
// compared against a table-driven reference model of arbitration, decode and watchdog.
module tb_conbus_arb_dec_n;
  localparam int NM      = 5;
  localparam int NS      = 7;
  localparam int DEC_W   = 3;
  localparam int TIMEOUT = 8;
  localparam logic [NS*DEC_W-1:0] S_MATCH = {3'd7, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [NS*DEC_W-1:0] S_MASK  = {3'b111, 3'b111, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};

  // Address map as plain tables: slave s claims tag t when (t & mask) == (match & mask).
  int ref_match [NS] = '{0, 1, 2, 3, 4, 5, 7};
  int ref_mask  [NS] = '{7, 7, 7, 7, 6, 7, 7};

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  conbus_arb_dec_n_if #(.NM(NM), .NS(NS)) bus_if ();

  conbus_arb_dec_n #(
    .NM(NM), .NS(NS), .DEC_W(DEC_W), .S_MATCH(S_MATCH), .S_MASK(S_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle_inputs();
    bus_if.m_dat_i = '0;
    bus_if.m_adr_i = '0;
    bus_if.m_cti_i = '0;
    bus_if.m_sel_i = '0;
    bus_if.m_we_i  = '0;
    bus_if.m_cyc_i = '0;
    bus_if.m_stb_i = '0;
    bus_if.s_dat_i = '0;
    bus_if.s_ack_i = '0;
  endtask

  task automatic drive_master(input int m, input logic req, input logic [31:0] adr, input logic [2:0] cti);
    bus_if.m_cyc_i[m]          = req;
    bus_if.m_stb_i[m]          = req;
    bus_if.m_adr_i[m*32 +: 32] = adr;
    bus_if.m_cti_i[m*3 +: 3]   = cti;
    bus_if.m_dat_i[m*32 +: 32] = 32'hDA7A_0000 | 32'(m);
  endtask

  // Returns at a falling edge with reset released and all inputs idle.
  task automatic apply_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    bus_if.m_cyc_i = '1;
    bus_if.m_stb_i = '1;
    bus_if.s_ack_i = '1;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL reset_m_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL reset_m_err got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    vectors++; if (bus_if.s_cyc_o !== 7'b0) begin miscompares++; $display("FAIL reset_s_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0); end
    vectors++; if (bus_if.s_stb_o !== 7'b0) begin miscompares++; $display("FAIL reset_s_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0); end
    @(negedge sys_clk);
    idle_inputs();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single_read();
    apply_reset();
    drive_master(0, 1'b1, 32'h0000_0010, 3'b000);
    bus_if.s_dat_i[31:0]  = 32'h1234_5678;
    bus_if.s_dat_i[63:32] = 32'hBAD0_0001;
    #2;
    vectors++; if (bus_if.s_cyc_o !== 7'b0000001) begin miscompares++; $display("FAIL read_s_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0000001); end
    vectors++; if (bus_if.s_stb_o !== 7'b0000001) begin miscompares++; $display("FAIL read_s_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0000001); end
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL read_early_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    bus_if.s_ack_i[3] = 1'b1;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL read_foreign_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    bus_if.s_ack_i = 7'b0000001;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b00001) begin miscompares++; $display("FAIL read_ack got=%b exp=%b", bus_if.m_ack_o, 5'b00001); end
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL read_err got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    vectors++; if (bus_if.m_dat_o !== {NM{32'h1234_5678}}) begin miscompares++; $display("FAIL read_data got=%h exp=%h", bus_if.m_dat_o, {NM{32'h1234_5678}}); end
    @(negedge sys_clk);
    idle_inputs();
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL read_ack_after got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] e;
    int who;
    apply_reset();
    for (int m = 0; m < NM; m++) drive_master(m, 1'b1, 32'h2000_0000, 3'b000);
    bus_if.s_ack_i = 7'b0000010;
    for (int k = 0; k < 6; k++) begin
      who = k % NM;
      e = '0;
      e[who] = 1'b1;
      #2;
      vectors++; if (bus_if.m_ack_o !== e) begin miscompares++; $display("FAIL rr_grant step=%0d got=%b exp=%b", k, bus_if.m_ack_o, e); end
      @(negedge sys_clk);
      drive_master(who, 1'b0, 32'h2000_0000, 3'b000);
      #2;
      vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL rr_gap step=%0d got=%b exp=%b", k, bus_if.m_ack_o, 5'b0); end
      @(negedge sys_clk);
      drive_master(who, 1'b1, 32'h2000_0000, 3'b000);
    end
    idle_inputs();
    @(negedge sys_clk);
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    apply_reset();
    drive_master(2, 1'b1, 32'h0000_0010, 3'b010);
    bus_if.s_ack_i = 7'b0000001;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL burst_latency got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    drive_master(1, 1'b1, 32'h0000_0010, 3'b000);
    for (int beat = 0; beat < 4; beat++) begin
      cti = (beat == 3) ? 3'b111 : 3'b010;
      bus_if.m_cti_i[2*3 +: 3] = cti;
      #2;
      vectors++; if (bus_if.m_ack_o !== 5'b00100) begin miscompares++; $display("FAIL burst_beat%0d_ack got=%b exp=%b", beat, bus_if.m_ack_o, 5'b00100); end
      vectors++; if (bus_if.s_cti_o[(NS-1)*3 +: 3] !== cti) begin miscompares++; $display("FAIL burst_beat%0d_cti got=%b exp=%b", beat, bus_if.s_cti_o[(NS-1)*3 +: 3], cti); end
      @(negedge sys_clk);
    end
    drive_master(2, 1'b0, 32'h0000_0010, 3'b000);
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL burst_gap_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    vectors++; if (bus_if.s_cyc_o !== 7'b0) begin miscompares++; $display("FAIL burst_gap_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0); end
    @(negedge sys_clk);
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b00010) begin miscompares++; $display("FAIL burst_next_owner got=%b exp=%b", bus_if.m_ack_o, 5'b00010); end
    @(negedge sys_clk);
    idle_inputs();
    @(negedge sys_clk);
  endtask

  task automatic test_decode_mask();
    apply_reset();
    drive_master(0, 1'b1, 32'hA000_0000, 3'b000);
    bus_if.s_ack_i = 7'b0100000;
    #2;
    vectors++; if (bus_if.s_cyc_o !== 7'b0010000) begin miscompares++; $display("FAIL dec_mask_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0010000); end
    vectors++; if (bus_if.s_stb_o !== 7'b0010000) begin miscompares++; $display("FAIL dec_mask_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0010000); end
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL dec_loser_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    drive_master(0, 1'b1, 32'h8000_0004, 3'b000);
    #2;
    vectors++; if (bus_if.s_cyc_o !== 7'b0010000) begin miscompares++; $display("FAIL dec_exact_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0010000); end
    vectors++; if (bus_if.s_adr_o[6*32 +: 32] !== 32'h8000_0004) begin miscompares++; $display("FAIL dec_adr_bcast got=%h exp=%h", bus_if.s_adr_o[6*32 +: 32], 32'h8000_0004); end
    @(negedge sys_clk);
    drive_master(0, 1'b1, 32'hE000_0000, 3'b000);
    bus_if.s_ack_i = 7'b1000000;
    #2;
    vectors++; if (bus_if.s_cyc_o !== 7'b1000000) begin miscompares++; $display("FAIL dec_top_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b1000000); end
    vectors++; if (bus_if.m_ack_o !== 5'b00001) begin miscompares++; $display("FAIL dec_top_ack got=%b exp=%b", bus_if.m_ack_o, 5'b00001); end
    @(negedge sys_clk);
    idle_inputs();
    @(negedge sys_clk);
  endtask

  task automatic test_unmapped();
    apply_reset();
    drive_master(0, 1'b1, 32'hC000_0000, 3'b000);
    bus_if.s_dat_i = '1;
    bus_if.s_ack_i = '1;
    #2;
    vectors++; if (bus_if.s_stb_o !== 7'b0) begin miscompares++; $display("FAIL unmap_s_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0); end
    vectors++; if (bus_if.s_cyc_o !== 7'b0) begin miscompares++; $display("FAIL unmap_s_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0); end
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL unmap_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL unmap_err_early got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    vectors++; if (bus_if.m_dat_o !== '0) begin miscompares++; $display("FAIL unmap_data got=%h exp=0", bus_if.m_dat_o); end
    @(negedge sys_clk);
    #2;
    vectors++; if (bus_if.m_err_o !== 5'b00001) begin miscompares++; $display("FAIL unmap_err got=%b exp=%b", bus_if.m_err_o, 5'b00001); end
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL unmap_err_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    #2;
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL unmap_err_width got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    @(negedge sys_clk);
    idle_inputs();
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    drive_master(0, 1'b1, 32'h3000_0000, 3'b000);
    for (int c = 1; c <= TIMEOUT; c++) begin
      #2;
      vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL wd_early_err cyc=%0d got=%b exp=%b", c, bus_if.m_err_o, 5'b0); end
      vectors++; if (bus_if.s_stb_o !== 7'b0000010) begin miscompares++; $display("FAIL wd_stb cyc=%0d got=%b exp=%b", c, bus_if.s_stb_o, 7'b0000010); end
      @(negedge sys_clk);
    end
    #2;
    vectors++; if (bus_if.m_err_o !== 5'b00001) begin miscompares++; $display("FAIL wd_err got=%b exp=%b", bus_if.m_err_o, 5'b00001); end
    vectors++; if (bus_if.s_stb_o !== 7'b0) begin miscompares++; $display("FAIL wd_stb_gate got=%b exp=%b", bus_if.s_stb_o, 7'b0); end
    vectors++; if (bus_if.m_ack_o !== 5'b0) begin miscompares++; $display("FAIL wd_err_ack got=%b exp=%b", bus_if.m_ack_o, 5'b0); end
    @(negedge sys_clk);
    drive_master(0, 1'b0, 32'h3000_0000, 3'b000);
    @(negedge sys_clk);
    drive_master(0, 1'b1, 32'h3000_0000, 3'b000);
    repeat (TIMEOUT - 1) @(negedge sys_clk);
    bus_if.s_ack_i = 7'b0000010;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b00001) begin miscompares++; $display("FAIL wd_late_ack got=%b exp=%b", bus_if.m_ack_o, 5'b00001); end
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL wd_late_ack_err got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    @(negedge sys_clk);
    idle_inputs();
    #2;
    vectors++; if (bus_if.m_err_o !== 5'b0) begin miscompares++; $display("FAIL wd_no_err_after_ack got=%b exp=%b", bus_if.m_err_o, 5'b0); end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_cycle();
    apply_reset();
    drive_master(3, 1'b1, 32'h0000_0010, 3'b000);
    @(negedge sys_clk);
    #2;
    vectors++; if (bus_if.s_stb_o !== 7'b0000001) begin miscompares++; $display("FAIL midrst_pre_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0000001); end
    drive_master(0, 1'b1, 32'h0000_0010, 3'b000);
    #1;
    sys_rst_n = 1'b0;
    #1;
    vectors++; if (bus_if.s_stb_o !== 7'b0) begin miscompares++; $display("FAIL midrst_stb got=%b exp=%b", bus_if.s_stb_o, 7'b0); end
    vectors++; if (bus_if.s_cyc_o !== 7'b0) begin miscompares++; $display("FAIL midrst_cyc got=%b exp=%b", bus_if.s_cyc_o, 7'b0); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bus_if.s_ack_i = 7'b0000001;
    #2;
    vectors++; if (bus_if.m_ack_o !== 5'b00001) begin miscompares++; $display("FAIL midrst_restart got=%b exp=%b", bus_if.m_ack_o, 5'b00001); end
    @(negedge sys_clk);
    idle_inputs();
    @(negedge sys_clk);
  endtask

  task automatic test_random();
    int mg, mw, sl, stall_pct;
    bit me, cyc_g, stb_g, acked;
    logic [31:0] a, e_dat;
    logic [NM-1:0] e_ack, e_err;
    logic [NS-1:0] e_scyc, e_sstb;
    apply_reset();
    mg = 0; mw = 0; me = 1'b0;
    for (int n = 0; n < 600; n++) begin
      stall_pct = (n < 300) ? 40 : 92;
      for (int m = 0; m < NM; m++) begin
        if (bus_if.m_cyc_i[m]) begin
          if ($urandom_range(99) < 12) bus_if.m_cyc_i[m] = 1'b0;
        end else if ($urandom_range(99) < 35) begin
          bus_if.m_cyc_i[m] = 1'b1;
        end
        bus_if.m_stb_i[m]          = bus_if.m_cyc_i[m] & ($urandom_range(99) < 88);
        bus_if.m_adr_i[m*32 +: 32] = {3'($urandom_range(7)), 29'($urandom)};
        bus_if.m_dat_i[m*32 +: 32] = $urandom;
        bus_if.m_cti_i[m*3 +: 3]   = 3'($urandom_range(7));
        bus_if.m_sel_i[m*4 +: 4]   = 4'($urandom_range(15));
        bus_if.m_we_i[m]           = 1'($urandom_range(1));
      end
      for (int s = 0; s < NS; s++) begin
        bus_if.s_ack_i[s]          = ($urandom_range(99) >= stall_pct);
        bus_if.s_dat_i[s*32 +: 32] = $urandom;
      end
      #2;
      a = bus_if.m_adr_i[mg*32 +: 32];
      sl = -1;
      for (int s = 0; s < NS; s++)
        if (sl < 0 && ((int'(a[31:29]) & ref_mask[s]) == (ref_match[s] & ref_mask[s]))) sl = s;
      cyc_g = bus_if.m_cyc_i[mg];
      stb_g = bus_if.m_stb_i[mg];
      acked = cyc_g && stb_g && sl >= 0 && !me && bus_if.s_ack_i[sl];
      e_ack = '0;  if (acked) e_ack[mg] = 1'b1;
      e_err = '0;  if (me) e_err[mg] = 1'b1;
      e_scyc = '0; if (cyc_g && sl >= 0) e_scyc[sl] = 1'b1;
      e_sstb = '0; if (stb_g && sl >= 0 && !me) e_sstb[sl] = 1'b1;
      e_dat = (sl >= 0) ? bus_if.s_dat_i[sl*32 +: 32] : 32'h0;
      vectors++; if (bus_if.m_ack_o !== e_ack) begin miscompares++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, bus_if.m_ack_o, e_ack); end
      vectors++; if (bus_if.m_err_o !== e_err) begin miscompares++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus_if.m_err_o, e_err); end
      vectors++; if (bus_if.s_cyc_o !== e_scyc) begin miscompares++; $display("FAIL rnd_s_cyc n=%0d got=%b exp=%b", n, bus_if.s_cyc_o, e_scyc); end
      vectors++; if (bus_if.s_stb_o !== e_sstb) begin miscompares++; $display("FAIL rnd_s_stb n=%0d got=%b exp=%b", n, bus_if.s_stb_o, e_sstb); end
      vectors++; if (bus_if.m_dat_o !== {NM{e_dat}}) begin miscompares++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, bus_if.m_dat_o, {NM{e_dat}}); end
      // Watchdog: count unacked strobe cycles, one-cycle error then a fresh start.
      if (me) begin
        me = 1'b0; mw = 0;
      end else if (!(cyc_g && stb_g) || acked) begin
        mw = 0;
      end else if (sl < 0 || mw + 1 == TIMEOUT) begin
        me = 1'b1;
      end else begin
        mw++;
      end
      if (!cyc_g) begin
        for (int k = 1; k < NM; k++) begin
          if (bus_if.m_cyc_i[(mg + k) % NM]) begin
            mg = (mg + k) % NM;
            break;
          end
        end
      end
      @(negedge sys_clk);
    end
    idle_inputs();
    @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    idle_inputs();
    @(negedge sys_clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_decode_mask();
    test_unmapped();
    test_timeout();
    test_reset_mid_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
